// File: rtl/text_pkg.sv
// Shared constants and types for the character-RAM raster reader.
// Latency: none (types, constants and an address helper only).
// Backpressure: n/a. Imported by text_ram_reader and rd_fifo2.
package text_pkg;

  localparam int ROWS   = 48;               // tabs per frame
  localparam int COLS   = 80;               // characters (str) per tab
  localparam int DATA_W = 8;                // character code width
  localparam int CELLS  = ROWS * COLS;

  localparam int ADDR_W = $clog2(CELLS);    // 12 bits at defaults
  localparam int TAB_W  = $clog2(ROWS);
  localparam int STR_W  = $clog2(COLS);

  localparam logic [DATA_W-1:0] CURSOR_CHAR = 8'h5F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // One buffered character with its screen position.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAB_W-1:0]  tab;
    logic [STR_W-1:0]  str;
  } cell_t;

  // Linear RAM address of a cell: tab*COLS + str, unsigned, ADDR_W wide.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [TAB_W-1:0] tab,
                                                  input logic [STR_W-1:0] str);
    return ADDR_W'(tab) * ADDR_W'(COLS) + ADDR_W'(str);
  endfunction

endpackage

// File: rtl/text_ram_reader_rd_fifo2.sv
// rd_fifo2: 2-entry skid buffer for {data, tab, str} cells, head-of-queue output.
// Latency: a push is visible at the head the cycle after it is written (occ was 0).
// Backpressure: none internally; the producer throttles using occ, push on full is not expected.
// Ports: clk/rst_n; push + push_cell write; pop removes head; head/occ report contents.
module rd_fifo2
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  cell_t      push_cell,
  input  logic       pop,
  output cell_t      head,
  output logic [1:0] occ
);

  cell_t      slot0_q, slot0_d;   // slot0 is always the head
  cell_t      slot1_q, slot1_d;
  logic [1:0] occ_q, occ_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_cell;
        else               slot1_d = push_cell;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps occupancy; new cell lands behind any survivor.
        if (occ_q == 2'd1) begin
          slot0_d = push_cell;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_cell;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head = slot0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/text_ram_reader.sv
// text_ram_reader: on start, reads all ROWS x COLS cells tab-major and streams code+position.
// Latency: start edge -> first out_valid 2 cycles; then 1 char/cycle with out_ready high.
// Backpressure: out_valid/out_ready; reads are throttled so buffer + in-flight never exceed 2.
// Ports: start/busy control; rd_en/rd_addr/rd_data synchronous RAM port (1-cycle read);
// out_* stream with sof/eol/eof markers; cur_tab/cur_str used only with TRR_CURSOR_EN defined.
module text_ram_reader
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [TAB_W-1:0]  out_tab,
  output logic [STR_W-1:0]  out_str,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  input  logic [TAB_W-1:0]  cur_tab,
  input  logic [STR_W-1:0]  cur_str
);

  rd_state_t         state_q, state_d;
  logic [TAB_W-1:0]  tab_q, tab_d;          // next cell to issue
  logic [STR_W-1:0]  str_q, str_d;
  logic              inflight_q, inflight_d;
  logic [TAB_W-1:0]  pend_tab_q, pend_tab_d; // position of the read in flight
  logic [STR_W-1:0]  pend_str_q, pend_str_d;

  cell_t             head;
  cell_t             cap_cell;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        load;
  logic              room;
  logic [DATA_W-1:0] cap_data;

  assign pop  = out_valid && out_ready;
  // Count the head being accepted this cycle as already gone, so a full
  // stream sustains one read per cycle without ever overfilling the buffer.
  assign load = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign room = (load < 3'd2);

  always_comb begin
    state_d    = state_q;
    tab_d      = tab_q;
    str_d      = str_q;
    pend_tab_d = pend_tab_q;
    pend_str_d = pend_str_q;
    rd_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          tab_d   = '0;
          str_d   = '0;
        end
      end
      ST_RUN: begin
        if (room) begin
          rd_en      = 1'b1;
          pend_tab_d = tab_q;
          pend_str_d = str_q;
          if (str_q == STR_W'(COLS - 1)) begin
            str_d = '0;
            if (tab_q == TAB_W'(ROWS - 1)) begin
              tab_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              tab_d = tab_q + TAB_W'(1);
            end
          end else begin
            str_d = str_q + STR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the last character is accepted so busy drops right after it.
        if (!inflight_q && (occ == 2'd0 || (occ == 2'd1 && pop))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d = rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tab_q      <= '0;
      str_q      <= '0;
      inflight_q <= 1'b0;
      pend_tab_q <= '0;
      pend_str_q <= '0;
    end else begin
      state_q    <= state_d;
      tab_q      <= tab_d;
      str_q      <= str_d;
      inflight_q <= inflight_d;
      pend_tab_q <= pend_tab_d;
      pend_str_q <= pend_str_d;
    end
  end

`ifdef TRR_CURSOR_EN
  // Cursor position is compared when the RAM data is captured.
  assign cap_data = (pend_tab_q == cur_tab && pend_str_q == cur_str) ? CURSOR_CHAR : rd_data;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cur_tab, cur_str};
  assign cap_data      = rd_data;
`endif

  assign cap_cell = '{data: cap_data, tab: pend_tab_q, str: pend_str_q};

  rd_fifo2 u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_cell (cap_cell),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign rd_addr   = cell_addr(tab_q, str_q);
  assign out_valid = (occ != 2'd0);
  assign out_data  = head.data;
  assign out_tab   = head.tab;
  assign out_str   = head.str;
  assign sof       = out_valid && head.tab == '0 && head.str == '0;
  assign eol       = out_valid && head.str == STR_W'(COLS - 1);
  assign eof       = out_valid && head.tab == TAB_W'(ROWS - 1) && head.str == STR_W'(COLS - 1);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_text_ram_reader.sv
module tb_text_ram_reader;
  import text_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] out_data;
  logic [TAB_W-1:0]  out_tab;
  logic [STR_W-1:0]  out_str;
  logic              out_valid;
  logic              out_ready;
  logic              sof, eol, eof, busy;
  logic [TAB_W-1:0]  cur_tab = TAB_W'(5);
  logic [STR_W-1:0]  cur_str = STR_W'(10);

  always #5 clk = ~clk;

  text_ram_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .out_data(out_data), .out_tab(out_tab), .out_str(out_str),
    .out_valid(out_valid), .out_ready(out_ready), .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .cur_tab(cur_tab), .cur_str(cur_str)
  );

  // Synchronous RAM preloaded with (addr mod 256).
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAB_W-1:0]  tab;
    logic [STR_W-1:0]  str;
    logic              sof, eol, eof;
  } exp_t;

  typedef struct {
    string name;
    int    ready_pct;
    int    restart_at;
    int    stall;
    int    abort_at;
    int    exp_eof_k;
  } scen_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t exp_cell(input int a);
    exp_t e;
    e.data = DATA_W'(a % 256);
`ifdef TRR_CURSOR_EN
    if (a == 5 * COLS + 10) e.data = 8'h5F;
`endif
    e.tab = TAB_W'(a / COLS);
    e.str = STR_W'(a % COLS);
    e.sof = (a == 0);
    e.eol = (a % COLS == COLS - 1);
    e.eof = (a == ROWS * COLS - 1);
    return e;
  endfunction

  task automatic run_frame(input scen_t sc);
    int   k, nchars, sof_c, eol_c, eof_c, first_k, eof_k;
    bit   restarted, busy_chk, done, aborted, prev_stall;
    exp_t got, prev_out, e;
    k = 0; nchars = 0; sof_c = 0; eol_c = 0; eof_c = 0; first_k = -1; eof_k = -1;
    restarted = 0; busy_chk = 0; done = 0; aborted = 0; prev_stall = 0; prev_out = '0;
    q.delete();
    for (int a = 0; a < CELLS; a++) q.push_back(exp_cell(a));
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b0;
    while (!done && !aborted && k < 20000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (sc.abort_at >= 0 && nchars >= sc.abort_at) begin
        rst_n = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk({sc.name, ":reset_outputs"},
            {rd_en, rd_addr, out_valid, out_data, out_tab, out_str, sof, eol, eof, busy}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        aborted = 1;
      end else begin
        if (sc.restart_at >= 0 && nchars == sc.restart_at && !restarted) begin
          start = 1'b1; restarted = 1;
        end
        if (sc.stall > 0 && k < sc.stall + 2) out_ready = 1'b0;
        else out_ready = ($urandom_range(99) < sc.ready_pct);
        @(negedge clk);
        if (k == 0) chk({sc.name, ":start_issue"}, {busy, rd_en, rd_addr}, {1'b1, 1'b1, ADDR_W'(0)});
        if (k == 1) chk({sc.name, ":no_early_valid"}, out_valid, 0);
        if (sc.stall > 0 && k == sc.stall + 1)
          chk({sc.name, ":stall_rd_hold"}, {out_valid, rd_en, rd_addr}, {1'b1, 1'b0, ADDR_W'(2)});
        if (first_k < 0 && out_valid) first_k = k;
        got = {out_data, out_tab, out_str, sof, eol, eof};
        if (prev_stall) chk({sc.name, ":stall_stable"}, {out_valid, got}, {1'b1, prev_out});
        if (busy_chk) begin
          chk({sc.name, ":busy_fall"}, busy, 0);
          done = 1;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk({sc.name, ":extra_char"}, nchars + 1, CELLS);
          end else begin
            e = q.pop_front();
            chk({sc.name, ":char"}, got, e);
            if (e.eof) begin eof_k = k; busy_chk = 1; end
          end
          nchars++;
          if (sof) sof_c++;
          if (eol) eol_c++;
          if (eof) eof_c++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = got;
        k++;
      end
    end
    chk({sc.name, ":first_valid_latency"}, first_k, 2);
    if (!aborted) begin
      if (!done) chk({sc.name, ":frame_timeout"}, k, 0);
      chk({sc.name, ":char_total"}, nchars, CELLS);
      chk({sc.name, ":left_in_queue"}, q.size(), 0);
      chk({sc.name, ":sof_count"}, sof_c, 1);
      chk({sc.name, ":eol_count"}, eol_c, ROWS);
      chk({sc.name, ":eof_count"}, eof_c, 1);
      if (sc.exp_eof_k >= 0) chk({sc.name, ":eof_cycle"}, eof_k, sc.exp_eof_k);
      repeat (10) begin
        @(negedge clk);
        chk({sc.name, ":no_restart"}, {busy, out_valid, rd_en}, 0);
      end
    end
  endtask

  initial begin
    scen_t tbl[6];
    //          name         ready restart stall abort eof_k
    tbl[0] = '{"full_rate",    100,   -1,    0,   -1, 3841};
    tbl[1] = '{"rand_ready",    50,   -1,    0,   -1,   -1};
    tbl[2] = '{"restart_ign",  100,  100,    0,   -1, 3841};
    tbl[3] = '{"stall20",      100,   -1,   20,   -1, 3861};
    tbl[4] = '{"reset_mid",    100,   -1,    0,  500,   -1};
    tbl[5] = '{"after_reset",  100,   -1,    0,   -1, 3841};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {rd_en, rd_addr, out_valid, out_data, out_tab, out_str, sof, eol, eof, busy}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, rd_en, out_valid}, 0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/text_ram_reader.md
# text_ram_reader

Raster-order reader for the 48-row × 80-column character RAM that the text-entry path fills. On a start pulse it walks every cell (tab-major, str-minor), issues synchronous RAM reads, and streams the character codes with their positions over a valid/ready interface toward the glyph renderer. Sits between the character RAM read port and the character-generator/video pipeline.

## Interface
- ROWS, 48, number of tabs (rows)
- COLS, 80, characters per row (str)
- DATA_W, 8, character code width
- CURSOR_CHAR, 8'h5F, code substituted at cursor cell (only with TRR_CURSOR_EN)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to read one full frame; ignored while busy
- rd_addr  out  $clog2(ROWS*COLS)  RAM read address = tab*COLS + str
- rd_en  out  1  read strobe; rd_data valid exactly one cycle after rd_en
- rd_data  in  DATA_W  RAM read data
- out_data  out  DATA_W  character code
- out_tab  out  $clog2(ROWS)  row of out_data
- out_str  out  $clog2(COLS)  column of out_data
- out_valid  out  1  out_* valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- sof  out  1  qualifies first character of frame (tab 0, str 0)
- eol  out  1  qualifies last character of a row (str COLS-1)
- eof  out  1  qualifies last character of frame
- busy  out  1  high from start acceptance until last character accepted
- cur_tab, cur_str  in  $clog2(ROWS), $clog2(COLS)  cursor position (ignored without TRR_CURSOR_EN)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: rd_en=0; start=1 → RUN, issue counters tab=0, str=0.
- RUN: rd_en=1 whenever buffer occupancy + in-flight read < 2; each issued read advances str; str==COLS-1 wraps to 0 and increments tab. Issuing tab=ROWS-1, str=COLS-1 → DRAIN.
- DRAIN: no reads; when buffer empty and no read in flight → IDLE.
- Returning data written into a 2-entry buffer together with its tab/str; buffer head drives out_*. Never overflows by construction; data never dropped or duplicated under any out_ready pattern.
- sof/eol/eof derived from head's tab/str, valid only with out_valid.
- Address arithmetic unsigned, width $clog2(ROWS*COLS) (12 bits at defaults); max address 3839.
- start while busy: ignored, no restart. start same cycle as final acceptance: ignored (busy still high).
- Reset mid-frame: all state cleared immediately; no partial resume.
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_tab=0, out_str=0, sof=eol=eof=0, busy=0.

## Timing
- start sampled at edge t: busy=1 and rd_en=1 with rd_addr=0 after t; data captured at t+2; out_valid=1 after t+2 (2-cycle start-to-first-valid latency).
- With out_ready held high: one character per cycle, full frame accepted in ROWS*COLS cycles after first valid; busy falls the cycle after eof acceptance.
- out_valid low→high only from buffer fill; out_* stable while out_valid && !out_ready.

## Configuration
- TRR_CURSOR_EN defined: when head tab==cur_tab and str==cur_str, out_data = CURSOR_CHAR instead of RAM data; cursor inputs sampled at capture time.
- Undefined: cursor ports unused, out_data always equals RAM data.

## Structure
- Shared package text_pkg: ROWS, COLS, DATA_W defaults, address/tab/str widths, reader state enum.
- Sub-module rd_fifo2: 2-entry skid buffer carrying {data, tab, str} with occupancy output.

## Test plan
- RAM preloaded with (addr mod 256); start, out_ready=1 → 3840 characters in order, first 8'h00 at tab 0 str 0, sof once, eol 48 times, eof on tab 47 str 79 value 8'hFF, 2-cycle latency.
- Random out_ready (50%) → identical sequence to previous test, no loss/duplication, out_* stable during stalls.
- start pulsed again at character 100 → ignored, frame completes once.
- rst_n low at character 500, then start → frame restarts from address 0, all outputs at reset values during reset.
- out_ready=0 for 20 cycles after first valid → rd_en drops after 2 reads outstanding, rd_addr holds at 2.
- TRR_CURSOR_EN, cursor (5,10) → address 410 emits 8'h5F, all other cells RAM data.
